// File: rtl/controle_horner_pkg.sv
// Shared types and encodings for the Horner-rule polynomial controller.
package controle_horner_pkg;

    // FSM states; encoding 3'd7 is unused and recovers to ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOADX = 3'd1,
        ST_MUL   = 3'd2,
        ST_ADD   = 3'd3,
        ST_STORE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // Accumulator input mux selects.
    localparam logic [1:0] H_SEL_ZERO = 2'b00;
    localparam logic [1:0] H_SEL_COEF = 2'b01;
    localparam logic [1:0] H_SEL_ALU  = 2'b10;

    // ALU operation select.
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_MUL = 1'b1;

endpackage

// File: rtl/controle_horner_if.sv
// Host/datapath-facing signal bundle of the Horner controller.
// master: the controller; slave: the host plus the datapath (BO).
interface controle_horner_if #(
    parameter int CW = 2
);
    logic          inicio;
    logic          cancela;
    logic          ovf;
    logic          lx;
    logic          lh;
    logic          ls;
    logic [1:0]    h_sel;
    logic [CW-1:0] coef_sel;
    logic          alu_op;
    logic          pronto;
    logic          ocupado;
    logic          erro;

    modport master (
        input  inicio, cancela, ovf,
        output lx, lh, ls, h_sel, coef_sel, alu_op, pronto, ocupado, erro
    );

    modport slave (
        output inicio, cancela, ovf,
        input  lx, lh, ls, h_sel, coef_sel, alu_op, pronto, ocupado, erro
    );
endinterface

// File: rtl/controle_horner_contador_coef.sv
// Loadable down-counter holding the index of the next coefficient to add.
// Saturates at zero so the index can never wrap.
module contador_coef #(
    parameter int CW = 2
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins over decrement; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {CW{1'b0}})) begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register, cleared by asynchronous reset.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/controle_horner.sv
// Control unit sequencing the polynomial datapath through Horner's rule:
// LOADX, then DEGREE pairs of MUL/ADD, then STORE and DONE. Moore outputs only.
module controle_horner #(
    parameter int DEGREE = 3
) (
    input  logic              ck,
    input  logic              rst,
    controle_horner_if.master bus
);
    import controle_horner_pkg::*;

    localparam int CW = $clog2(DEGREE + 1);

    state_t        state_q;
    state_t        state_d;
    logic          erro_q;
    logic          erro_d;
    logic [CW-1:0] idx_s;
    logic          idx_zero_s;

    logic          lx_s;
    logic          lh_s;
    logic          ls_s;
    logic [1:0]    h_sel_s;
    logic [CW-1:0] coef_sel_s;
    logic          alu_op_s;
    logic          pronto_s;
    logic          ocupado_s;

    contador_coef #(.CW(CW)) u_idx (
        .ck         (ck),
        .rst        (rst),
        .load_i     (state_q == ST_LOADX),
        .load_val_i (CW'(DEGREE - 1)),
        .dec_i      (state_q == ST_ADD),
        .cnt_o      (idx_s),
        .zero_o     (idx_zero_s)
    );

    // Next state: normal sequencing, then overflow, then abort (highest priority).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = bus.inicio ? ST_LOADX : ST_IDLE;
            ST_LOADX: state_d = ST_MUL;
            ST_MUL:   state_d = ST_ADD;
            ST_ADD:   state_d = idx_zero_s ? ST_STORE : ST_MUL;
            ST_STORE: state_d = ST_DONE;
            ST_DONE:  state_d = bus.inicio ? ST_LOADX : ST_IDLE;
            ST_ERR:   state_d = bus.inicio ? ST_LOADX : ST_ERR;
            default:  state_d = ST_IDLE;
        endcase
        if (((state_q == ST_MUL) || (state_q == ST_ADD)) && bus.ovf) begin
            state_d = ST_ERR;
        end else begin
            state_d = state_d;
        end
        if ((state_q != ST_IDLE) && bus.cancela) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Sticky error flag: set on entry to ERR, cleared when a new run starts or ERR is aborted.
    always_comb begin
        erro_d = erro_q;
        if (state_d == ST_ERR) begin
            erro_d = 1'b1;
        end else if (state_d == ST_LOADX) begin
            erro_d = 1'b0;
        end else if ((state_q == ST_ERR) && (state_d == ST_IDLE)) begin
            erro_d = 1'b0;
        end else begin
            erro_d = erro_q;
        end
    end

    // State and error registers with asynchronous reset.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            erro_q  <= erro_d;
        end
    end

    // Moore output decode from the state register and coefficient index.
    always_comb begin
        lx_s       = 1'b0;
        lh_s       = 1'b0;
        ls_s       = 1'b0;
        h_sel_s    = H_SEL_ZERO;
        coef_sel_s = {CW{1'b0}};
        alu_op_s   = ALU_ADD;
        pronto_s   = 1'b0;
        ocupado_s  = 1'b0;
        case (state_q)
            ST_LOADX: begin
                lx_s       = 1'b1;
                lh_s       = 1'b1;
                h_sel_s    = H_SEL_COEF;
                coef_sel_s = CW'(DEGREE);
                ocupado_s  = 1'b1;
            end
            ST_MUL: begin
                lh_s      = 1'b1;
                h_sel_s   = H_SEL_ALU;
                alu_op_s  = ALU_MUL;
                ocupado_s = 1'b1;
            end
            ST_ADD: begin
                lh_s       = 1'b1;
                h_sel_s    = H_SEL_ALU;
                alu_op_s   = ALU_ADD;
                coef_sel_s = idx_s;
                ocupado_s  = 1'b1;
            end
            ST_STORE: begin
                ls_s      = 1'b1;
                ocupado_s = 1'b1;
            end
            ST_DONE: begin
                pronto_s = 1'b1;
            end
            default: begin
                lx_s = 1'b0;
            end
        endcase
    end

    assign bus.lx       = lx_s;
    assign bus.lh       = lh_s;
    assign bus.ls       = ls_s;
    assign bus.h_sel    = h_sel_s;
    assign bus.coef_sel = coef_sel_s;
    assign bus.alu_op   = alu_op_s;
    assign bus.pronto   = pronto_s;
    assign bus.ocupado  = ocupado_s;
    assign bus.erro     = erro_q;

endmodule

// File: tb/tb_controle_horner.sv
// Directed bench for controle_horner: a DEGREE=3 instance driving a small
// datapath model, plus DEGREE=1 and DEGREE=15 instances for latency checks.
module tb_controle_horner;

    logic ck;
    logic rst;
    int   checks;
    int   errors;

    controle_horner_if #(.CW(2)) bus3 ();
    controle_horner_if #(.CW(1)) bus1 ();
    controle_horner_if #(.CW(4)) bus15 ();

    controle_horner #(.DEGREE(3))  u3  (.ck(ck), .rst(rst), .bus(bus3));
    controle_horner #(.DEGREE(1))  u1  (.ck(ck), .rst(rst), .bus(bus1));
    controle_horner #(.DEGREE(15)) u15 (.ck(ck), .rst(rst), .bus(bus15));

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Datapath model: x=2, p(x) = 1*x^3 + 0*x^2 + 2*x + 5 -> p(2) = 17.
    int coef [4];
    int x_r, h_r, s_r;
    initial begin
        coef[0] = 5; coef[1] = 2; coef[2] = 0; coef[3] = 1;
    end

    always @(posedge ck or negedge rst) begin
        if (!rst) begin
            x_r <= 0; h_r <= 0; s_r <= 0;
        end else begin
            if (bus3.lx) x_r <= 2;
            if (bus3.lh) begin
                case (bus3.h_sel)
                    2'b00:   h_r <= 0;
                    2'b01:   h_r <= coef[bus3.coef_sel];
                    2'b10:   h_r <= bus3.alu_op ? h_r * x_r : h_r + coef[bus3.coef_sel];
                    default: h_r <= -1;
                endcase
            end
            if (bus3.ls) s_r <= h_r;
        end
    end

    // {lx, lh, ls, h_sel[1:0], coef_sel[1:0], alu_op, pronto, ocupado, erro}
    function automatic logic [10:0] vec3();
        return {bus3.lx, bus3.lh, bus3.ls, bus3.h_sel, bus3.coef_sel,
                bus3.alu_op, bus3.pronto, bus3.ocupado, bus3.erro};
    endfunction

    // Expected outputs for cycles 1..9 of one DEGREE=3 run.
    logic [10:0] exp_run [9];
    initial begin
        exp_run[0] = 11'b11001110010; // LOADX coef 3
        exp_run[1] = 11'b01010001010; // MUL
        exp_run[2] = 11'b01010100010; // ADD coef 2
        exp_run[3] = 11'b01010001010; // MUL
        exp_run[4] = 11'b01010010010; // ADD coef 1
        exp_run[5] = 11'b01010001010; // MUL
        exp_run[6] = 11'b01010000010; // ADD coef 0
        exp_run[7] = 11'b00100000010; // STORE
        exp_run[8] = 11'b00000000100; // DONE
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if (vec3() !== 11'd0) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", vec3(), 11'd0);
        end
        tick(); tick();
        rst = 1'b1;
        // Start a run and pull reset while in the first ADD.
        bus3.inicio = 1'b1; tick(); bus3.inicio = 1'b0;
        tick(); tick();
        checks++;
        if (vec3() !== exp_run[2]) begin
            errors++; $display("FAIL reset_reach_add: got %b expected %b", vec3(), exp_run[2]);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (vec3() !== 11'd0) begin
            errors++; $display("FAIL reset_mid_add: got %b expected %b", vec3(), 11'd0);
        end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (vec3() !== 11'd0) begin
                errors++; $display("FAIL reset_quiet c%0d: got %b expected %b", k, vec3(), 11'd0);
            end
            tick();
        end
    endtask

    task automatic test_single_run();
        bus3.inicio = 1'b1; tick(); bus3.inicio = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if (vec3() !== exp_run[k-1]) begin
                errors++; $display("FAIL run_seq c%0d: got %b expected %b", k, vec3(), exp_run[k-1]);
            end
            tick();
        end
        checks++;
        if (s_r !== 17) begin
            errors++; $display("FAIL run_result: got %0d expected %0d", s_r, 17);
        end
        checks++;
        if (vec3() !== 11'd0) begin
            errors++; $display("FAIL run_idle_after: got %b expected %b", vec3(), 11'd0);
        end
    endtask

    task automatic test_back_to_back();
        bus3.inicio = 1'b1; tick();
        for (int k = 1; k <= 27; k++) begin
            checks++;
            if ({bus3.pronto, bus3.lx} !== {(k % 9) == 0, (k % 9) == 1}) begin
                errors++; $display("FAIL b2b c%0d: got pronto,lx=%b%b expected %b%b",
                                   k, bus3.pronto, bus3.lx, (k % 9) == 0, (k % 9) == 1);
            end
            if ((k % 9) == 0) begin
                checks++;
                if (s_r !== 17) begin
                    errors++; $display("FAIL b2b_result c%0d: got %0d expected %0d", k, s_r, 17);
                end
            end
            if (k == 27) bus3.inicio = 1'b0;
            tick();
        end
        checks++;
        if (vec3() !== 11'd0) begin
            errors++; $display("FAIL b2b_idle: got %b expected %b", vec3(), 11'd0);
        end
    endtask

    task automatic test_cancela();
        bus3.inicio = 1'b1; tick(); bus3.inicio = 1'b0;
        tick(); tick(); tick(); // second MUL
        checks++;
        if (vec3() !== exp_run[3]) begin
            errors++; $display("FAIL cancel_reach_mul: got %b expected %b", vec3(), exp_run[3]);
        end
        bus3.cancela = 1'b1; tick(); bus3.cancela = 1'b0;
        checks++;
        if (vec3() !== 11'd0) begin
            errors++; $display("FAIL cancel_idle: got %b expected %b", vec3(), 11'd0);
        end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if ({bus3.ls, bus3.pronto, bus3.ocupado} !== 3'b000) begin
                errors++; $display("FAIL cancel_quiet c%0d: got %b expected %b",
                                   k, {bus3.ls, bus3.pronto, bus3.ocupado}, 3'b000);
            end
            tick();
        end
    endtask

    task automatic test_ovf();
        bus3.inicio = 1'b1; tick(); bus3.inicio = 1'b0;
        for (int k = 2; k <= 5; k++) tick(); // cycle 5: ADD with idx 1
        checks++;
        if (vec3() !== exp_run[4]) begin
            errors++; $display("FAIL ovf_reach_add: got %b expected %b", vec3(), exp_run[4]);
        end
        bus3.ovf = 1'b1; tick(); bus3.ovf = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checks++;
            if ({bus3.erro, bus3.ocupado, bus3.lx, bus3.lh, bus3.ls, bus3.pronto} !== 6'b100000) begin
                errors++; $display("FAIL ovf_err_hold c%0d: got %b expected %b", k,
                    {bus3.erro, bus3.ocupado, bus3.lx, bus3.lh, bus3.ls, bus3.pronto}, 6'b100000);
            end
            tick();
        end
        bus3.inicio = 1'b1; tick(); bus3.inicio = 1'b0;
        checks++;
        if (vec3() !== exp_run[0]) begin
            errors++; $display("FAIL ovf_restart: got %b expected %b", vec3(), exp_run[0]);
        end
        for (int k = 2; k <= 9; k++) tick();
        checks++;
        if ({bus3.pronto, s_r == 17} !== 2'b11) begin
            errors++; $display("FAIL ovf_rerun: got pronto=%b s=%0d expected pronto=1 s=17", bus3.pronto, s_r);
        end
        // Overflow in MUL, then abort from ERR.
        tick();
        bus3.inicio = 1'b1; tick(); bus3.inicio = 1'b0;
        tick();
        bus3.ovf = 1'b1; tick(); bus3.ovf = 1'b0;
        checks++;
        if ({bus3.erro, bus3.ocupado} !== 2'b10) begin
            errors++; $display("FAIL ovf_mul_err: got %b expected %b", {bus3.erro, bus3.ocupado}, 2'b10);
        end
        bus3.cancela = 1'b1; tick(); bus3.cancela = 1'b0;
        checks++;
        if (vec3() !== 11'd0) begin
            errors++; $display("FAIL err_cancel: got %b expected %b", vec3(), 11'd0);
        end
    endtask

    task automatic test_degree1();
        int first;
        int zeros;
        first = 0; zeros = 0;
        bus1.inicio = 1'b1; tick(); bus1.inicio = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus1.pronto && first == 0) first = k;
            if (bus1.lh && bus1.h_sel == 2'b10 && !bus1.alu_op && bus1.coef_sel == '0) zeros++;
            tick();
        end
        checks++;
        if (first !== 5) begin
            errors++; $display("FAIL deg1_latency: got %0d expected %0d", first, 5);
        end
        checks++;
        if (zeros !== 1) begin
            errors++; $display("FAIL deg1_coef0: got %0d expected %0d", zeros, 1);
        end
    endtask

    task automatic test_degree15();
        int first;
        int zeros;
        first = 0; zeros = 0;
        bus15.inicio = 1'b1; tick(); bus15.inicio = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus15.pronto && first == 0) first = k;
            if (bus15.lh && bus15.h_sel == 2'b10 && !bus15.alu_op && bus15.coef_sel == '0) zeros++;
            tick();
        end
        checks++;
        if (first !== 33) begin
            errors++; $display("FAIL deg15_latency: got %0d expected %0d", first, 33);
        end
        checks++;
        if (zeros !== 1) begin
            errors++; $display("FAIL deg15_coef0: got %0d expected %0d", zeros, 1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus3.inicio = 1'b0;  bus3.cancela = 1'b0;  bus3.ovf = 1'b0;
        bus1.inicio = 1'b0;  bus1.cancela = 1'b0;  bus1.ovf = 1'b0;
        bus15.inicio = 1'b0; bus15.cancela = 1'b0; bus15.ovf = 1'b0;
        test_reset();
        test_single_run();
        test_back_to_back();
        test_cancela();
        test_ovf();
        test_degree1();
        test_degree15();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
